// File: rtl/card_pkg.sv
// Shared types and constants for the card display path: blank code, highest
// legal card code, scheduler FSM states and hand identifiers.
package card_pkg;

  localparam logic [5:0] CARD_BLANK = 6'd63;
  localparam logic [5:0] CARD_MAX   = 6'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_e;

  typedef enum logic {
    PLAYER = 1'b0,
    DEALER = 1'b1
  } hand_e;

endpackage

// File: rtl/card_display_scheduler_dwell_timer.sv
// Reloadable down-counter: load presets CYCLES-1, expire is high on the last
// cycle of each CYCLES-long interval.
module dwell_timer #(
  parameter int unsigned CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expire
);

  localparam int W = $clog2(CYCLES);
  localparam logic [W-1:0] RELOAD = W'(CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/card_display_scheduler.sv
// Stores player/dealer card codes from two arbitrated requesters and
// time-shares the single glyph decoder between the hands, one card per dwell.
module card_display_scheduler
  import card_pkg::*;
#(
  parameter int unsigned MAX_CARDS    = 8,
  parameter int unsigned DWELL_CYCLES = 50_000_000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          p_req,
  input  logic [5:0]                    p_card,
  output logic                          p_ack,
  input  logic                          d_req,
  input  logic [5:0]                    d_card,
  output logic                          d_ack,
  input  logic                          clear,
  input  logic                          hide_hole,
  output logic [5:0]                    displayNum,
  output logic                          hand_sel,
  output logic [$clog2(MAX_CARDS)-1:0]  slot_idx,
  output logic [$clog2(MAX_CARDS):0]    p_count,
  output logic [$clog2(MAX_CARDS):0]    d_count,
  output logic                          overflow,
  output state_e                        dbg_state
);

  localparam int SW = $clog2(MAX_CARDS);
  localparam int CW = SW + 1;
  localparam logic [SW-1:0] HOLE_SLOT = SW'(1);

  // Handshake: a requester holds req and card until a one-cycle ack; the card
  // is written on the edge that raises ack, and a side is never re-granted
  // during its own ack cycle, so it may drop req or change card right after.

  state_e          state_q, state_d;
  hand_e           hand_q, hand_d;
  hand_e           last_q, last_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [5:0]      disp_q, disp_d;
  logic [CW-1:0]   p_count_q, p_count_d, d_count_q, d_count_d;
  logic            p_ack_q, p_ack_d, d_ack_q, d_ack_d, ovf_q, ovf_d;
  logic [5:0]      p_mem_q [MAX_CARDS];
  logic [5:0]      d_mem_q [MAX_CARDS];

  logic            p_elig, d_elig, gnt_p, gnt_d, p_full, d_full;
  logic            wr_en;
  hand_e           wr_hand;
  logic [SW-1:0]   wr_addr;
  logic [5:0]      wr_data;
  logic            expire, timer_load;
  logic [CW-1:0]   cur_cnt, oth_cnt, slot_next;
  hand_e           oth_hand;

  dwell_timer #(.CYCLES(DWELL_CYCLES)) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .expire (expire)
  );

  always_comb begin
    p_elig = p_req && !p_ack_q;
    d_elig = d_req && !d_ack_q;
    gnt_p  = 1'b0;
    gnt_d  = 1'b0;
    if (!clear) begin
      if (p_elig && d_elig) begin
        gnt_p = (last_q == DEALER);
        gnt_d = (last_q == PLAYER);
      end else begin
        gnt_p = p_elig;
        gnt_d = d_elig;
      end
    end
    p_full  = (p_count_q == CW'(MAX_CARDS));
    d_full  = (d_count_q == CW'(MAX_CARDS));
    p_ack_d = gnt_p;
    d_ack_d = gnt_d;
    ovf_d   = (gnt_p && p_full) || (gnt_d && d_full);
    last_d  = last_q;
    if (gnt_p) begin
      last_d = PLAYER;
    end else if (gnt_d) begin
      last_d = DEALER;
    end
    wr_en   = (gnt_p && !p_full) || (gnt_d && !d_full);
    wr_hand = gnt_d ? DEALER : PLAYER;
    wr_addr = gnt_d ? d_count_q[SW-1:0] : p_count_q[SW-1:0];
    wr_data = gnt_d ? d_card : p_card;
    if (clear) begin
      p_count_d = '0;
      d_count_d = '0;
    end else begin
      p_count_d = p_count_q + CW'(gnt_p && !p_full);
      d_count_d = d_count_q + CW'(gnt_d && !d_full);
    end
  end

  always_comb begin
    state_d    = state_q;
    hand_d     = hand_q;
    slot_d     = slot_q;
    oth_hand   = (hand_q == PLAYER) ? DEALER : PLAYER;
    cur_cnt    = (hand_q == DEALER) ? d_count_q : p_count_q;
    oth_cnt    = (hand_q == DEALER) ? p_count_q : d_count_q;
    slot_next  = {1'b0, slot_q} + CW'(1);
    timer_load = clear || (state_q == IDLE) || expire;
    case (state_q)
      IDLE: begin
        if (p_count_q != '0) begin
          state_d = SHOW;
          hand_d  = PLAYER;
          slot_d  = '0;
        end else if (d_count_q != '0) begin
          state_d = SHOW;
          hand_d  = DEALER;
          slot_d  = '0;
        end
      end
      SHOW: begin
        if (expire) begin
          if (slot_next < cur_cnt) begin
            slot_d = slot_q + SW'(1);
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (expire) begin
          slot_d = '0;
          if (oth_cnt != '0) begin
            state_d = SHOW;
            hand_d  = oth_hand;
          end else if (cur_cnt != '0) begin
            state_d = SHOW;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
      hand_d  = PLAYER;
      slot_d  = '0;
    end
    // Look up from the next state so the shown code changes on the same edge
    // as the slot; hide_hole is re-evaluated every cycle, not latched.
    disp_d = CARD_BLANK;
    if (state_d == SHOW) begin
      if (hand_d == DEALER) begin
        disp_d = (hide_hole && slot_d == HOLE_SLOT) ? CARD_BLANK : d_mem_q[slot_d];
      end else begin
        disp_d = p_mem_q[slot_d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hand_q    <= PLAYER;
      last_q    <= DEALER;
      slot_q    <= '0;
      disp_q    <= CARD_BLANK;
      p_count_q <= '0;
      d_count_q <= '0;
      p_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hand_q    <= hand_d;
      last_q    <= last_d;
      slot_q    <= slot_d;
      disp_q    <= disp_d;
      p_count_q <= p_count_d;
      d_count_q <= d_count_d;
      p_ack_q   <= p_ack_d;
      d_ack_q   <= d_ack_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_CARDS; i++) begin
        p_mem_q[i] <= '0;
        d_mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      if (wr_hand == DEALER) begin
        d_mem_q[wr_addr] <= wr_data;
      end else begin
        p_mem_q[wr_addr] <= wr_data;
      end
    end
  end

  assign displayNum = disp_q;
  assign hand_sel   = hand_q;
  assign slot_idx   = slot_q;
  assign p_count    = p_count_q;
  assign d_count    = d_count_q;
  assign p_ack      = p_ack_q;
  assign d_ack      = d_ack_q;
  assign overflow   = ovf_q;
  assign dbg_state  = state_q;

endmodule
